// File: rtl/sc_phase_pkg.sv
// sc_phase_pkg: shared constants for the sc_phase_det phase detector.
//   state_t    - controller states (IDLE / ROT / DONE)
//   GUARD_BITS - extra integer bits on the x/y datapath
//   FRAC_BITS  - extra fractional bits on the phase accumulator
//   atan_lut() - atan(2^-k) expressed as a fraction of a full circle
package sc_phase_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    localparam int unsigned GUARD_BITS = 2;
    localparam int unsigned FRAC_BITS  = 4;

    // atan(2^-k) scaled so that 2^32 is a full turn. The result is rounded
    // to zw bits, also with a full turn at 2^zw. zw must be 1..31.
    function automatic logic [31:0] atan_lut(input logic [3:0] k, input int unsigned zw);
        logic [31:0] t;
        case (k)
            4'd0:  t = 32'h2000_0000;
            4'd1:  t = 32'h12E4_051E;
            4'd2:  t = 32'h09FB_385B;
            4'd3:  t = 32'h0511_11D4;
            4'd4:  t = 32'h028B_0D43;
            4'd5:  t = 32'h0145_D7E1;
            4'd6:  t = 32'h00A2_F61E;
            4'd7:  t = 32'h0051_7C55;
            4'd8:  t = 32'h0028_BE53;
            4'd9:  t = 32'h0014_5F2F;
            4'd10: t = 32'h000A_2F98;
            4'd11: t = 32'h0005_17CC;
            4'd12: t = 32'h0002_8BE6;
            4'd13: t = 32'h0001_45F3;
            4'd14: t = 32'h0000_A2FA;
            default: t = 32'h0000_517D;
        endcase
        return (t + (32'd1 << (31 - zw))) >> (32 - zw);
    endfunction

endpackage

// File: rtl/sc_phase_det_cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring-mode CORDIC micro-rotation.
//   x, y     - signed vector components before the rotation
//   z        - phase accumulator (unsigned, wraps mod 2^zw)
//   k        - rotation index (shift amount)
//   atan_k   - angle of this rotation in accumulator units
//   x_next, y_next, z_next - values after the rotation
// The rotation direction drives y toward zero; both shifts use the
// pre-update x and y.
module cordic_vec_stage #(
    parameter int unsigned xw = 16,
    parameter int unsigned zw = 14
) (
    input  logic signed [xw-1:0] x,
    input  logic signed [xw-1:0] y,
    input  logic        [zw-1:0] z,
    input  logic        [3:0]    k,
    input  logic        [zw-1:0] atan_k,
    output logic signed [xw-1:0] x_next,
    output logic signed [xw-1:0] y_next,
    output logic        [zw-1:0] z_next
);

    logic signed [xw-1:0] xs;
    logic signed [xw-1:0] ys;

    always_comb begin
        xs = x >>> k;
        ys = y >>> k;
        if (!y[xw-1]) begin
            x_next = x + ys;
            y_next = y - xs;
            z_next = z + atan_k;
        end else begin
            x_next = x - ys;
            y_next = y + xs;
            z_next = z - atan_k;
        end
    end

endmodule

// File: rtl/sc_phase_det.sv
// sc_phase_det: recovers a LUT-style phase code and a gain-scaled magnitude
// from a signed I/Q pair using an iterative vectoring CORDIC.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake (one transaction in flight)
//   i_in, q_in           - signed cosine / sine components (dsz bits)
//   out_valid / out_ready- output handshake; results hold while stalled
//   phase                - unsigned phase code, full circle = 2^asz
//   mag                  - magnitude times the CORDIC gain (~1.6468)
module sc_phase_det
    import sc_phase_pkg::*;
#(
    parameter int unsigned asz   = 10,
    parameter int unsigned dsz   = 14,
    parameter int unsigned niter = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [dsz-1:0] i_in,
    input  logic signed [dsz-1:0] q_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic        [asz-1:0] phase,
    output logic        [dsz:0]   mag
);

    localparam int unsigned XW = dsz + GUARD_BITS;
    localparam int unsigned ZW = asz + FRAC_BITS;

    state_t state, state_nx;

    logic signed [XW-1:0] x, y, x_nx, y_nx;
    logic signed [XW-1:0] i_ext, q_ext;
    logic        [ZW-1:0] z, z_nx, atan_cur;
    logic        [3:0]    k;
    logic                 zero_in;
    logic                 last;

    assign i_ext    = {{GUARD_BITS{i_in[dsz-1]}}, i_in};
    assign q_ext    = {{GUARD_BITS{q_in[dsz-1]}}, q_in};
    assign atan_cur = ZW'(atan_lut(k, ZW));
    assign last     = (k == 4'(niter - 1));

    cordic_vec_stage #(
        .xw (XW),
        .zw (ZW)
    ) u_stage (
        .x      (x),
        .y      (y),
        .z      (z),
        .k      (k),
        .atan_k (atan_cur),
        .x_next (x_nx),
        .y_next (y_nx),
        .z_next (z_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ROT;
            end
            ROT: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            k       <= '0;
            zero_in <= 1'b0;
            phase   <= '0;
            mag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Fold the left half-plane onto the right so the
                        // micro-rotations only ever cover +/-90 degrees.
                        if (i_in[dsz-1]) begin
                            x <= -i_ext;
                            y <= -q_ext;
                            z <= {1'b1, {(ZW-1){1'b0}}};
                        end else begin
                            x <= i_ext;
                            y <= q_ext;
                            z <= '0;
                        end
                        zero_in <= (i_in == '0) && (q_in == '0);
                        k       <= '0;
                    end
                end
                ROT: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    k <= k + 4'd1;
                    if (last) begin
                        mag   <= x_nx[dsz:0];
                        // Round half-up on the fractional bits; the add
                        // wraps so codes just below a full turn give 0.
                        phase <= zero_in ? '0
                               : asz'((z_nx + ZW'(1 << (FRAC_BITS - 1))) >> FRAC_BITS);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sc_phase_det.md
Name: sc_phase_det

Overview:
Inverse of the sine/cosine lookup table: recovers the phase address from a signed cosine/sine (I/Q) sample pair. It uses an iterative CORDIC in vectoring mode. The phase output uses the same address convention as the LUT: full circle = 2^asz codes, code 0 = angle 0, code 2^(asz-2) = +90°. It also returns the vector magnitude (CORDIC-gain scaled). It sits on the receive/measurement side, e.g. in phase-tracking or LUT self-check paths.

Parameters:
asz, 10, bits in output phase word (matches LUT address width)
dsz, 14, bits in signed I/Q input words (matches LUT data width)
niter, 12, CORDIC micro-rotations; legal range asz+1 to 16

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  I/Q pair presented
in_ready  output  1  block can accept a pair
i_in  input  dsz  signed cosine component
q_in  input  dsz  signed sine component
out_valid  output  1  result available
out_ready  input  1  consumer takes result
phase  output  asz  unsigned phase code, mod 2^asz
mag  output  dsz+1  unsigned magnitude × ~1.6468 (gain not removed)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, phase=0, mag=0, all internal registers 0.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready is 1 only in IDLE. One transaction is in flight at a time.
- States:
  - IDLE: on input transfer, latch and pre-rotate, then go to ROT with k=0.
  - ROT: one micro-rotation per cycle, k=0..niter-1. After k=niter-1 go to DONE.
  - DONE: out_valid=1. On output transfer go to IDLE. phase and mag hold stable while out_ready=0.
- Latency: input transfer at cycle 0 gives out_valid at cycle niter+1. Throughput is one result per niter+2 cycles when out_ready is tied high.
- Pre-rotation (at latch):
  - Sign-extend I/Q to dsz+2 bits.
  - If i_in<0: x=-I, y=-Q, z=half-circle. Otherwise x=I, y=Q, z=0.
  - Two guard bits make negating -2^(dsz-1) exact.
- Micro-rotation k:
  - If y>=0: x+=y>>>k, y-=x>>>k, z+=atan_k.
  - Otherwise: x-=y>>>k, y+=x>>>k, z-=atan_k.
  - Shifts are arithmetic and use the pre-update x and y.
- Phase accumulator z is asz+4 bits unsigned and wraps modulo 2^(asz+4).
- atan_k = round(atan(2^-k) · 2^(asz+4) / 2π).
- Output:
  - phase = (z + 2^3) >> 4, truncated to asz bits. Round-half-up, wraps so that codes near full circle yield 0.
  - mag = x[dsz:0], with x ≥ 0 guaranteed after iteration.
- Boundaries:
  - I=Q=0: phase=0, mag=0 (y stays 0, so y>=0 branch is taken each step; z accumulates). Special case: if the latched x==0 && y==0, force phase=0.
  - Input with in_valid held high during ROT/DONE is ignored and not latched until IDLE.
  - Simultaneous output transfer and new in_valid in DONE: output completes, and the new input is accepted no earlier than the following cycle (IDLE).
  - rst_n asserted mid-operation: the transaction is aborted immediately and no partial result is ever presented.
- Accuracy: |phase error| ≤ 1 LSB for |vector| ≥ 2^(dsz-4).

Decomposition:
- Package sc_phase_pkg: the atan_k constant table (function or localparam array, computed for asz+4 bits, up to 16 entries), the state encoding (IDLE/ROT/DONE), and the guard-bit and fraction-bit constants (2, 4).
- Sub-module cordic_vec_stage: combinational single micro-rotation. Inputs are x, y, z, k and atan_k; outputs are next x, y, z. It is instantiated once and iterated by the FSM.

Test Plan (asz=10, dsz=14, niter=12):
- Cardinal axes:
  - I=8191,Q=0 -> phase=0, mag=13489±2.
  - I=0,Q=8191 -> phase=256.
  - I=-8191,Q=0 -> phase=512.
  - I=0,Q=-8191 -> phase=768.
  - Each with out_valid exactly 13 cycles after accept.
- Full sweep: I=round(8191·cos(2πa/1024)), Q=round(8191·sin(2πa/1024)) for a=0..1023 -> phase==a±1. Also check a=1023 and a=0 for wrap without error.
- Extremes:
  - I=-8192,Q=-8192 -> phase=640±1, mag≈19079, no overflow.
  - I=Q=0 -> phase=0, mag=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> phase/mag/out_valid stable, in_ready=0, a new in_valid pulse is ignored. Release -> one transfer, then in_ready=1 next cycle.
- Reset mid-op: pulse rst_n low at ROT k=5 -> out_valid=0 and in_ready=1 immediately (asynchronous). The next transaction I=0,Q=8191 returns 256.
